// File: rtl/nes_pkg.sv
// Shared NES definitions used by the sprite DMA engine and the bus glue around it.
//   dma_state_t  : sprite DMA sequencer states
//   NES_DMA_REG  : cpu register address that starts a sprite DMA ($4014)
//   NES_OAM_DATA : PPU OAM data port that every DMA write targets ($2004)
`timescale 1ns/1ps
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] NES_DMA_REG  = 16'h4014;
  localparam logic [15:0] NES_OAM_DATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// NES sprite DMA engine.
// A cpu write to DMA_REG_ADDR latches the written byte as a source page and
// halts the cpu. The engine then copies XFER_LEN bytes from {page,8'h00}
// upward to OAM_DATA_ADDR, one read cycle followed by one write cycle per
// byte. Reads always start on an even cycle (parity 0), so a trigger that
// lands on an odd cycle costs one extra alignment cycle.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   reset      : asynchronous, active-low
//   cpu_addr   : cpu address bus (watched for the trigger write)
//   cpu_write  : cpu write strobe
//   cpu_d_out  : cpu write data, source page number on a trigger
//   bus_d_in   : memory read data, valid in the same cycle as the address
//   ready      : to cpu; 0 halts the cpu
//   dma_active : 1 while the engine owns the bus (READ/WRITE cycles)
//   dma_addr   : DMA bus address (0 when not active)
//   dma_write  : DMA write strobe (0 when not active)
//   dma_d_out  : DMA write data (0 when not active)
`timescale 1ns/1ps
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        ready,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_write,
  output logic [7:0]  dma_d_out
);

  // The byte index is 8 bits wide, so the last index is XFER_LEN-1 = 8'hFF
  // and the increment after it wraps to 0 without touching the page.
  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic        parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      page   <= '0;
      idx    <= '0;
      data   <= '0;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_d_out;
            idx   <= '0;
            state <= HALT;
          end
        end
        // parity is 1 here means the next cycle has parity 0, so the first
        // read can go straight away; otherwise burn one cycle in ALIGN.
        HALT:  state <= parity ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          data  <= bus_d_in;
          state <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == IDX_LAST) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register so that an asynchronous
  // reset releases the cpu and the bus in the same instant.
  always_comb begin
    ready      = (state == IDLE);
    dma_active = 1'b0;
    dma_addr   = '0;
    dma_write  = 1'b0;
    dma_d_out  = '0;
    case (state)
      READ: begin
        dma_active = 1'b1;
        dma_addr   = {page, idx};
      end
      WRITE: begin
        dma_active = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        dma_write  = 1'b1;
        dma_d_out  = data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for the sprite DMA engine: a 64 KiB combinational memory,
// a parity reference and a per-transfer collector of bus activity.
`timescale 1ns/1ps
module tb_oam_dma;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_out = 8'h00;
  logic [7:0]  bus_d_in;
  logic        ready;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_write;
  logic [7:0]  dma_d_out;

  logic [7:0]  mem [0:65535];
  logic        tb_par;

  int n_checks = 0;
  int n_pass   = 0;

  // per-transfer results
  int          r_lo, r_first_rd, r_first_wr, r_rd, r_wr;
  int          r_bad_rd, r_bad_wr, r_hit0, r_bad_ctl;
  logic [15:0] r_last_rd;
  logic [7:0]  r_first_wd, r_last_wd;

  always #5 clk = ~clk;

  assign bus_d_in = mem[dma_active ? dma_addr : cpu_addr];

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .bus_d_in   (bus_d_in),
    .ready      (ready),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_write  (dma_write),
    .dma_d_out  (dma_d_out)
  );

  // Reference parity: 0 during the first cycle after reset release.
  always @(posedge clk or negedge reset)
    if (!reset) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Trigger a transfer from page pg (waiting for the requested parity unless
  // want_par < 0) and follow it until ready returns, sampling at negedges.
  task automatic xfer(input logic [7:0] pg, input int want_par, input bit inject);
    int k;
    logic [7:0] ri, wi;
    while (want_par >= 0 && tb_par != want_par[0]) @(negedge clk);
    cpu_addr = NES_DMA_REG; cpu_write = 1'b1; cpu_d_out = pg;
    @(negedge clk);
    cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    r_lo = 0; r_first_rd = -1; r_first_wr = -1; r_rd = 0; r_wr = 0;
    r_bad_rd = 0; r_bad_wr = 0; r_hit0 = 0; r_bad_ctl = 0;
    r_last_rd = 16'h0000; r_first_wd = 8'h00; r_last_wd = 8'h00;
    ri = 8'h00; wi = 8'h00;
    k = 1;
    while (!ready && k < 700) begin
      r_lo++;
      if (dma_active && !dma_write) begin
        if (r_first_rd < 0) r_first_rd = k;
        if (dma_addr != {pg, ri}) r_bad_rd++;
        r_last_rd = dma_addr;
        ri++; r_rd++;
      end else if (dma_active && dma_write) begin
        if (r_first_wr < 0) begin r_first_wr = k; r_first_wd = dma_d_out; end
        if (dma_addr != NES_OAM_DATA || dma_d_out != mem[{pg, wi}]) r_bad_wr++;
        r_last_wd = dma_d_out;
        wi++; r_wr++;
      end else if (dma_write || dma_addr != 16'h0000 || dma_d_out != 8'h00) begin
        r_bad_ctl++;
      end
      if (dma_active && dma_addr == 16'h0000) r_hit0++;
      // a trigger attempt while busy must be ignored
      if (inject && k == 10) begin cpu_addr = NES_DMA_REG; cpu_write = 1'b1; cpu_d_out = 8'h07; end
      if (inject && k == 11) begin cpu_addr = 16'h0000; cpu_write = 1'b0; cpu_d_out = 8'h00; end
      @(negedge clk);
      k++;
    end
    cpu_write = 1'b0;
    chk("xfer_done", k < 700, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, wcnt, act;
    logic [7:0] nb;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 13 + (a >> 8));
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;

    // Reset state, with a trigger held while reset is low
    cpu_addr = NES_DMA_REG; cpu_write = 1'b1; cpu_d_out = 8'h02;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_active", dma_active, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_write", dma_write, 0);
    chk("rst_dout", dma_d_out, 0);
    reset = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_trig_ignored", ready, 1);

    // Non-trigger accesses
    cpu_addr = 16'h4013; cpu_write = 1'b1; cpu_d_out = 8'h02;
    @(negedge clk);
    cpu_write = 1'b0;
    @(negedge clk);
    chk("nt_4013_ready", ready, 1);
    cpu_addr = 16'h4015; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0;
    @(negedge clk);
    chk("nt_4015_ready", ready, 1);
    cpu_addr = NES_DMA_REG; cpu_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("nt_rd4014_ready", ready, 1);
    chk("nt_rd4014_active", dma_active, 0);
    cpu_addr = 16'h0000;
    @(negedge clk);

    // Even start
    xfer(8'h02, 0, 1'b0);
    chk("even_len", r_lo, 513);
    chk("even_first_rd", r_first_rd, 2);
    chk("even_first_wr", r_first_wr, 3);
    chk("even_reads", r_rd, 256);
    chk("even_writes", r_wr, 256);
    chk("even_bad_rd", r_bad_rd, 0);
    chk("even_bad_wr", r_bad_wr, 0);
    chk("even_idle_bus", r_bad_ctl, 0);
    chk("even_ready_after", ready, 1);

    // Odd start
    xfer(8'h02, 1, 1'b0);
    chk("odd_len", r_lo, 514);
    chk("odd_first_rd", r_first_rd, 3);
    chk("odd_first_wr", r_first_wr, 4);
    chk("odd_bad_rd", r_bad_rd, 0);
    chk("odd_idle_bus", r_bad_ctl, 0);

    // Data path from page 03, with a trigger attempt while busy
    @(negedge clk);
    xfer(8'h03, -1, 1'b1);
    chk("dp_len_ok", (r_lo == 513 || r_lo == 514), 1);
    chk("dp_writes", r_wr, 256);
    chk("dp_bad_wr", r_bad_wr, 0);
    chk("dp_bad_rd", r_bad_rd, 0);
    chk("dp_first_byte", r_first_wd, 8'h5A);
    chk("dp_last_byte", r_last_wd, 8'hA5);

    // Wrap on page FF, then a back-to-back trigger in the first IDLE cycle
    xfer(8'hFF, -1, 1'b0);
    chk("wrap_last_rd", r_last_rd, 16'hFFFF);
    chk("wrap_reads", r_rd, 256);
    chk("wrap_no_0000", r_hit0, 0);
    chk("wrap_bad_rd", r_bad_rd, 0);
    chk("wrap_ready_after", ready, 1);
    xfer(8'h04, -1, 1'b0);
    chk("b2b_len_ok", (r_lo == 513 || r_lo == 514), 1);
    chk("b2b_reads", r_rd, 256);
    chk("b2b_bad_rd", r_bad_rd, 0);
    chk("b2b_bad_wr", r_bad_wr, 0);

    // Abort with reset during the write of byte 100
    @(negedge clk);
    cpu_addr = NES_DMA_REG; cpu_write = 1'b1; cpu_d_out = 8'h06;
    @(negedge clk);
    cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    wcnt = 0; k = 0;
    while (k < 400) begin
      if (dma_write) begin
        if (wcnt == 100) break;
        wcnt++;
      end
      @(negedge clk);
      k++;
    end
    nb = mem[16'h0664];
    chk("ab_in_write", dma_write, 1);
    chk("ab_wr_addr", dma_addr, 16'h2004);
    chk("ab_wr_data", dma_d_out, nb);
    #2 reset = 1'b0;
    #1;
    chk("ab_ready_async", ready, 1);
    chk("ab_active_async", dma_active, 0);
    chk("ab_write_async", dma_write, 0);
    chk("ab_addr_async", dma_addr, 0);
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (dma_active || !ready) act++;
    end
    chk("ab_quiet_in_reset", act, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ab_ready_released", ready, 1);
    xfer(8'h05, -1, 1'b0);
    chk("ab_new_reads", r_rd, 256);
    chk("ab_new_bad_rd", r_bad_rd, 0);
    chk("ab_new_bad_wr", r_bad_wr, 0);
    chk("ab_new_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
